// File: rtl/sticker_sampler.sv
// Samples the live CCD raster at nine sticker centres: accumulates a square
// window around each centre over one frame and presents the averaged RGB triples.
module sticker_sampler #(
    parameter int unsigned WIN_LOG2 = 2,
    parameter int unsigned PIX_W    = 10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [98:0]          CentersX,
    input  logic [98:0]          CentersY,
    input  logic [10:0]          iX,
    input  logic [10:0]          iY,
    input  logic [PIX_W-1:0]     iR,
    input  logic [PIX_W-1:0]     iG,
    input  logic [PIX_W-1:0]     iB,
    input  logic                 iDVAL,
    input  logic                 iFrameStart,
    output logic [9*PIX_W-1:0]   oR,
    output logic [9*PIX_W-1:0]   oG,
    output logic [9*PIX_W-1:0]   oB,
    output logic                 busy,
    output logic                 done,
    output logic                 partial
);

    localparam int unsigned NB    = 9;
    localparam int unsigned CW    = 11;
    localparam int unsigned WIN   = 2 ** WIN_LOG2;
    localparam int unsigned HALF  = WIN / 2;
    localparam int unsigned NSAMP = WIN * WIN;
    localparam int unsigned SUM_W = PIX_W + 2 * WIN_LOG2;
    localparam int unsigned CNT_W = 2 * WIN_LOG2 + 1;

    typedef enum logic [2:0] {IDLE, ARM, ACCUM, FINISH, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cx [NB];
    logic [CW-1:0]      cy [NB];
    logic [SUM_W-1:0]   sum_r [NB];
    logic [SUM_W-1:0]   sum_g [NB];
    logic [SUM_W-1:0]   sum_b [NB];
    logic [CNT_W-1:0]   cnt [NB];
    logic               eof;

    logic [CW:0]        wx_c [NB];
    logic [CW:0]        wy_c [NB];
    logic [NB-1:0]      hit_c;
    logic [NB-1:0]      full_c;
    logic               acc_en_c;

    // Window membership of the current pixel; one extra bit keeps WX+3 from wrapping.
    always_comb begin
        hit_c    = '0;
        full_c   = '0;
        acc_en_c = iDVAL && ((state == ARM && iFrameStart) ||
                             (state == ACCUM && !iFrameStart && !eof));
        for (int k = 0; k < NB; k++) begin
            wx_c[k]   = (cx[k] < CW'(HALF)) ? '0 : {1'b0, cx[k] - CW'(HALF)};
            wy_c[k]   = (cy[k] < CW'(HALF)) ? '0 : {1'b0, cy[k] - CW'(HALF)};
            hit_c[k]  = ({1'b0, iX} >= wx_c[k]) && ({1'b0, iX} <= wx_c[k] + (CW+1)'(WIN - 1)) &&
                        ({1'b0, iY} >= wy_c[k]) && ({1'b0, iY} <= wy_c[k] + (CW+1)'(WIN - 1));
            full_c[k] = (cnt[k] == CNT_W'(NSAMP));
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            eof     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            partial <= 1'b0;
            oR      <= '0;
            oG      <= '0;
            oB      <= '0;
            for (int k = 0; k < NB; k++) begin
                cx[k]    <= '0;
                cy[k]    <= '0;
                sum_r[k] <= '0;
                sum_g[k] <= '0;
                sum_b[k] <= '0;
                cnt[k]   <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int k = 0; k < NB; k++) begin
                            cx[k]    <= CentersX[k*CW +: CW];
                            cy[k]    <= CentersY[k*CW +: CW];
                            sum_r[k] <= '0;
                            sum_g[k] <= '0;
                            sum_b[k] <= '0;
                            cnt[k]   <= '0;
                        end
                        eof     <= 1'b0;
                        done    <= 1'b0;
                        partial <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ARM;
                    end
                end
                ARM: begin
                    if (iFrameStart) state <= ACCUM;
                end
                ACCUM: begin
                    // The frame-end pulse is only recorded here, so both exits share FINISH timing.
                    if ((&full_c) || eof) state <= FINISH;
                    else if (iFrameStart) eof <= 1'b1;
                end
                FINISH: begin
                    for (int k = 0; k < NB; k++) begin
                        oR[k*PIX_W +: PIX_W] <= PIX_W'(sum_r[k] >> (2 * WIN_LOG2));
                        oG[k*PIX_W +: PIX_W] <= PIX_W'(sum_g[k] >> (2 * WIN_LOG2));
                        oB[k*PIX_W +: PIX_W] <= PIX_W'(sum_b[k] >> (2 * WIN_LOG2));
                    end
                    partial <= ~(&full_c);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase

            for (int k = 0; k < NB; k++) begin
                if (acc_en_c && hit_c[k] && !full_c[k]) begin
                    sum_r[k] <= sum_r[k] + SUM_W'(iR);
                    sum_g[k] <= sum_g[k] + SUM_W'(iG);
                    sum_b[k] <= sum_b[k] + SUM_W'(iB);
                    cnt[k]   <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

endmodule
